// File: rtl/alu_pkg.sv
// alu_pkg: shared width, select codes and entry layout for the ALU output stage.
// Optional ALU_OUT_PARITY_EN adds a parity bit to each stored entry.
package alu_pkg;
    localparam int ALU_WIDTH = 4;
    localparam logic [1:0] SEL_IN0 = 2'd0;
    localparam logic [1:0] SEL_IN1 = 2'd1;
    localparam logic [1:0] SEL_IN2 = 2'd2;
    localparam logic [1:0] SEL_IN3 = 2'd3;
    typedef struct packed {
        logic [ALU_WIDTH-1:0] data;
        logic [1:0]           tag;
`ifdef ALU_OUT_PARITY_EN
        logic                 parity;
`endif
    } entry_t;
endpackage

// File: rtl/alu_out_stage_if.sv
// alu_out_stage_if: upstream capture and downstream delivery signals of the output stage.
// Optional ALU_OUT_PARITY_EN adds out_parity.
interface alu_out_stage_if #(parameter int WIDTH = 4, parameter int CNT_W = 8);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_tag;
    logic             out_zero;
    logic [CNT_W-1:0] out_count;
`ifdef ALU_OUT_PARITY_EN
    logic             out_parity;
    modport master (output in_valid, in_data, in_sel, out_ready,
                    input in_ready, out_valid, out_data, out_tag, out_zero, out_count, out_parity);
    modport slave (input in_valid, in_data, in_sel, out_ready,
                   output in_ready, out_valid, out_data, out_tag, out_zero, out_count, out_parity);
`else
    modport master (output in_valid, in_data, in_sel, out_ready,
                    input in_ready, out_valid, out_data, out_tag, out_zero, out_count);
    modport slave (input in_valid, in_data, in_sel, out_ready,
                   output in_ready, out_valid, out_data, out_tag, out_zero, out_count);
`endif
endinterface

// File: rtl/alu_out_slot.sv
// alu_out_slot: one registered entry with valid flag; load wins over clear.
module alu_out_slot import alu_pkg::*; #(parameter type T = entry_t) (
    input  logic clk,
    input  logic rst_n,
    input  logic ld_i,
    input  logic clr_i,
    input  T     d_i,
    output T     q_o,
    output logic v_o
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= '0;
            v_o <= 1'b0;
        end else if (ld_i) begin
            q_o <= d_i;
            v_o <= 1'b1;
        end else if (clr_i) begin
            q_o <= '0;
            v_o <= 1'b0;
        end
    end
endmodule

// File: rtl/alu_out_stage.sv
// alu_out_stage: 2-entry in-order head/skid buffer after the ALU result mux, with delivery counter.
// Optional ALU_OUT_PARITY_EN stores even parity per entry and drives out_parity.
module alu_out_stage import alu_pkg::*; #(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = 8
) (
    input logic            clk,
    input logic            rst_n,
    alu_out_stage_if.slave bus
);
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [1:0]       tag;
`ifdef ALU_OUT_PARITY_EN
        logic             parity;
`endif
    } slot_t;
    slot_t            in_e, head_q, skid_q, head_d;
    logic             head_v, skid_v, push, pop, head_ld, skid_ld;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Occupancy is 2 exactly when the skid slot is valid, so in_ready comes straight from a flop.
    always_comb begin
        in_e      = '0;
        in_e.data = bus.in_data;
        in_e.tag  = bus.in_sel;
`ifdef ALU_OUT_PARITY_EN
        in_e.parity = ^bus.in_data;
`endif
        push    = bus.in_valid && !skid_v;
        pop     = head_v && bus.out_ready;
        head_ld = (push && (!head_v || pop)) || (pop && skid_v);
        head_d  = skid_v ? skid_q : in_e;
        skid_ld = push && head_v && !pop;
        cnt_d   = pop ? cnt_q + 1'b1 : cnt_q;
    end
    alu_out_slot #(.T(slot_t)) u_head (
        .clk(clk), .rst_n(rst_n), .ld_i(head_ld), .clr_i(pop),
        .d_i(head_d), .q_o(head_q), .v_o(head_v)
    );
    alu_out_slot #(.T(slot_t)) u_skid (
        .clk(clk), .rst_n(rst_n), .ld_i(skid_ld), .clr_i(pop),
        .d_i(in_e), .q_o(skid_q), .v_o(skid_v)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
    assign bus.in_ready  = !skid_v;
    assign bus.out_valid = head_v;
    assign bus.out_data  = head_q.data;
    assign bus.out_tag   = head_q.tag;
    assign bus.out_zero  = head_v && (head_q.data == '0);
    assign bus.out_count = cnt_q;
`ifdef ALU_OUT_PARITY_EN
    assign bus.out_parity = head_v && head_q.parity;
`endif
endmodule

// File: doc/alu_out_stage.md
ALU_OUT_STAGE -- requirements
Module: alu_out_stage

Interface
REQ-001 Parameter: WIDTH, 4, result data width in bits.
REQ-002 Parameter: CNT_W, 8, width of the delivered-result counter.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_valid  input  1  upstream 4:1 mux output holds a result to capture.
REQ-006 Port: in_data  input  WIDTH  result from the upstream mux (its out).
REQ-007 Port: in_sel  input  2  select code that produced in_data; carried as a tag.
REQ-008 Port: in_ready  output  1  stage can accept a result this cycle.
REQ-009 Port: out_valid  output  1  head entry is presented downstream.
REQ-010 Port: out_ready  input  1  downstream consumes head entry this cycle.
REQ-011 Port: out_data  output  WIDTH  head entry data.
REQ-012 Port: out_tag  output  2  head entry select tag.
REQ-013 Port: out_zero  output  1  high when out_data equals 0 and out_valid is high, else low.
REQ-014 Port: out_count  output  CNT_W  number of results delivered downstream, modulo 2^CNT_W.

Function
REQ-015 Stage SHALL be a 2-entry in-order buffer (head slot + skid slot) with occupancy 0, 1 or 2.
REQ-016 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-017 in_ready SHALL be a registered function of state: high when occupancy < 2, low when 2; it SHALL NOT depend combinationally on in_valid or out_ready.
REQ-018 out_valid SHALL be high exactly when occupancy != 0.
REQ-019 Latency: a result pushed into an empty stage at edge N SHALL appear on out_data/out_tag with out_valid high in the cycle after edge N.
REQ-020 Occupancy 1, simultaneous push and pop: occupancy SHALL stay 1 and the pushed entry SHALL become head after the edge.
REQ-021 Occupancy 2: no push is possible (in_ready low); a pop SHALL move the skid entry to head and raise in_ready after the edge.
REQ-022 While out_valid && !out_ready, out_data, out_tag and out_zero SHALL hold stable.
REQ-023 Entries SHALL be delivered in push order; no entry is dropped or duplicated.
REQ-024 out_count SHALL increment by 1 on each pop and wrap from 2^CNT_W-1 to 0.
REQ-025 in_valid with in_ready low SHALL be ignored; upstream holds the value.

Reset
REQ-026 On rst_n low, occupancy SHALL go to 0 immediately; out_valid 0, in_ready 1, out_data 0, out_tag 0, out_zero 0, out_count 0.
REQ-027 Reset asserted mid-transfer SHALL discard both slots; first push after deassertion behaves as into an empty stage.
REQ-028 Deassertion SHALL take effect at the first rising clk edge with rst_n high.

Configuration
REQ-029 Macro ALU_OUT_PARITY_EN: when defined, each entry SHALL store even parity of in_data, exposed on extra port out_parity (output, 1, XOR of out_data bits; 0 in reset and when out_valid low).
REQ-030 Without ALU_OUT_PARITY_EN, out_parity port and parity storage SHALL be absent; all other behaviour identical.

Structure
REQ-031 Shared package alu_pkg SHALL hold ALU_WIDTH (4), the sel code constants SEL_IN0..SEL_IN3 (0..3), and the entry struct typedef {data, tag, parity}.
REQ-032 One sub-module alu_out_slot (single registered entry with load/clear) SHALL be instantiated twice for head and skid.

Verification
REQ-033 Reset then push data 4'hA tag 2 with out_ready=1 -> next cycle out_valid 1, out_data A, out_tag 2, out_zero 0; following cycle out_count 1.
REQ-034 out_ready=0, push 4'h3 then 4'h0 -> occupancy 2, in_ready 0, out_data holds 3; raise out_ready -> 3 then 0 delivered in order, out_zero 1 for the second, in_ready back to 1.
REQ-035 Occupancy 1 (head 4'h5), push 4'h9 with out_ready=1 same cycle -> after edge head 9, out_valid 1, occupancy 1.
REQ-036 Stream 256 results with out_ready=1 -> out_count wraps 255 to 0; no gaps when in_valid held high.
REQ-037 Occupancy 2, assert rst_n low between clk edges -> outputs reach REQ-026 values without a clock edge; push 4'h7 after release -> delivered as first entry.
REQ-038 With ALU_OUT_PARITY_EN, push 4'hB -> out_parity 1; push 4'h6 -> out_parity 0.
